// File: rtl/ex_mem_stage_pkg.sv
// Shared CPU definitions: ALUFun class/sub-op encodings (also used by the control unit)
// and the EX/MEM pipeline register layout.
package ex_mem_stage_pkg;

  typedef enum logic [1:0] {
    CLS_ARITH = 2'b00,
    CLS_LOGIC = 2'b01,
    CLS_SHIFT = 2'b10,
    CLS_CMP   = 2'b11
  } alu_class_e;

  localparam logic [3:0] LOG_AND  = 4'b1000;
  localparam logic [3:0] LOG_OR   = 4'b1110;
  localparam logic [3:0] LOG_XOR  = 4'b0110;
  localparam logic [3:0] LOG_NOR  = 4'b0001;
  localparam logic [3:0] LOG_PASS = 4'b1010;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b11;

  localparam logic [2:0] CMP_NE  = 3'b000;
  localparam logic [2:0] CMP_EQ  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b010;
  localparam logic [2:0] CMP_LTZ = 3'b101;
  localparam logic [2:0] CMP_LEZ = 3'b110;
  localparam logic [2:0] CMP_GTZ = 3'b111;

  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] wr_data;
    logic [31:0] pc;
    logic [4:0]  wr_reg;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic        mem_wr;
    logic        mem_rd;
    logic        reg_wr;
    logic        ovf;
  } ex_mem_t;

  // Two's-complement overflow: operands agree in sign but the result does not.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/ex_mem_stage_alu.sv
// Combinational ALU: arithmetic, logic, shift and compare classes selected by ALUFun,
// plus zero / signed-overflow / negative flags derived from the adder.
module alu
  import ex_mem_stage_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [5:0]  ALUFun,
  input  logic        Sign,
  output logic [31:0] S,
  output logic        Z,
  output logic        V,
  output logic        N
);

  alu_class_e  cls_s;
  logic [31:0] b_eff_s;
  logic [31:0] sum_s;
  logic [31:0] logic_s;
  logic [31:0] shift_s;
  logic [31:0] cmp_s;
  logic        ovf_raw_s;
  logic        borrow_s;
  logic        lt_s;

  // Shared adder; subtraction is A + ~B + 1 and also feeds the flags.
  always_comb begin
    cls_s     = alu_class_e'(ALUFun[5:4]);
    b_eff_s   = ALUFun[0] ? ~B : B;
    sum_s     = A + b_eff_s + {31'd0, ALUFun[0]};
    ovf_raw_s = add_overflow(A[31], b_eff_s[31], sum_s[31]);
    borrow_s  = (A < B);
    lt_s      = Sign ? ($signed(A) < $signed(B)) : borrow_s;
  end

  // Bitwise operations.
  always_comb begin
    case (ALUFun[3:0])
      LOG_AND:  logic_s = A & B;
      LOG_OR:   logic_s = A | B;
      LOG_XOR:  logic_s = A ^ B;
      LOG_NOR:  logic_s = ~(A | B);
      LOG_PASS: logic_s = A;
      default:  logic_s = 32'd0;
    endcase
  end

  // Shifts move B by A[4:0].
  always_comb begin
    case (ALUFun[1:0])
      SH_SLL:  shift_s = B << A[4:0];
      SH_SRL:  shift_s = B >> A[4:0];
      SH_SRA:  shift_s = $signed(B) >>> A[4:0];
      default: shift_s = 32'd0;
    endcase
  end

  // Compares; the zero tests treat A as signed regardless of Sign.
  always_comb begin
    case (ALUFun[3:1])
      CMP_EQ:  cmp_s = {31'd0, (A == B)};
      CMP_NE:  cmp_s = {31'd0, (A != B)};
      CMP_LT:  cmp_s = {31'd0, lt_s};
      CMP_LEZ: cmp_s = {31'd0, (A[31] || (A == 32'd0))};
      CMP_LTZ: cmp_s = {31'd0, A[31]};
      CMP_GTZ: cmp_s = {31'd0, (!A[31] && (A != 32'd0))};
      default: cmp_s = 32'd0;
    endcase
  end

  // Result select and flags.
  always_comb begin
    case (cls_s)
      CLS_ARITH: S = sum_s;
      CLS_LOGIC: S = logic_s;
      CLS_SHIFT: S = shift_s;
      CLS_CMP:   S = cmp_s;
      default:   S = 32'd0;
    endcase
    Z = (sum_s == 32'd0);
    V = Sign && (cls_s == CLS_ARITH) && ovf_raw_s;
    N = Sign ? sum_s[31] : borrow_s;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX stage ALU plus the EX/MEM pipeline register with flush/stall control and
// optional overflow trapping that cancels register and memory writes.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter bit OVF_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [5:0]  EX_ALUFun,
  input  logic        EX_Sign,
  input  logic [31:0] EX_BusA,
  input  logic [31:0] EX_BusB,
  input  logic        EX_MemWr,
  input  logic        EX_MemRd,
  input  logic        EX_RegWr,
  input  logic [1:0]  EX_RegDst,
  input  logic [1:0]  EX_MemtoReg,
  input  logic [4:0]  EX_WrReg,
  input  logic [31:0] EX_PC,
  output logic [31:0] MEM_ALUOut,
  output logic [31:0] MEM_WrData,
  output logic [31:0] MEM_PC,
  output logic [4:0]  MEM_WrReg,
  output logic [1:0]  MEM_RegDst,
  output logic [1:0]  MEM_MemtoReg,
  output logic        MEM_MemWr,
  output logic        MEM_MemRd,
  output logic        MEM_RegWr,
  output logic        MEM_Ovf,
  output logic        Z,
  output logic        V,
  output logic        N
);

  logic [31:0] alu_s;
  logic        trap_s;
  ex_mem_t     load_s;
  ex_mem_t     bubble_s;
  ex_mem_t     mem_r;

  alu u_alu (
    .A      (EX_BusA),
    .B      (EX_BusB),
    .ALUFun (EX_ALUFun),
    .Sign   (EX_Sign),
    .S      (alu_s),
    .Z      (Z),
    .V      (V),
    .N      (N)
  );

  // Candidate register contents for a normal load and for a bubble.
  always_comb begin
    trap_s              = OVF_TRAP && V;
    load_s.alu_out      = alu_s;
    load_s.wr_data      = EX_BusB;
    load_s.pc           = EX_PC;
    load_s.wr_reg       = EX_WrReg;
    load_s.reg_dst      = EX_RegDst;
    load_s.mem_to_reg   = EX_MemtoReg;
    load_s.mem_wr       = EX_MemWr && !trap_s;
    load_s.mem_rd       = EX_MemRd;
    load_s.reg_wr       = EX_RegWr && !trap_s;
    load_s.ovf          = V;
    bubble_s            = load_s;
    bubble_s.mem_wr     = 1'b0;
    bubble_s.mem_rd     = 1'b0;
    bubble_s.reg_wr     = 1'b0;
    bubble_s.ovf        = 1'b0;
  end

  // EX/MEM register: reset > flush > stall > load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_r <= '0;
    end else if (flush) begin
      mem_r <= bubble_s;
    end else if (stall) begin
      mem_r <= mem_r;
    end else begin
      mem_r <= load_s;
    end
  end

  assign MEM_ALUOut   = mem_r.alu_out;
  assign MEM_WrData   = mem_r.wr_data;
  assign MEM_PC       = mem_r.pc;
  assign MEM_WrReg    = mem_r.wr_reg;
  assign MEM_RegDst   = mem_r.reg_dst;
  assign MEM_MemtoReg = mem_r.mem_to_reg;
  assign MEM_MemWr    = mem_r.mem_wr;
  assign MEM_MemRd    = mem_r.mem_rd;
  assign MEM_RegWr    = mem_r.reg_wr;
  assign MEM_Ovf      = mem_r.ovf;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: expected MEM_* contents are queued when an
// instruction is driven and popped one edge later for comparison.
module tb_ex_mem_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [4:0]  wreg;
    logic [1:0]  rdst;
    logic [1:0]  m2r;
    logic        mw;
    logic        mr;
    logic        rw;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [5:0]  f;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  EX_ALUFun = 6'd0;
  logic        EX_Sign = 1'b0;
  logic [31:0] EX_BusA = 32'd0;
  logic [31:0] EX_BusB = 32'd0;
  logic        EX_MemWr = 1'b0;
  logic        EX_MemRd = 1'b0;
  logic        EX_RegWr = 1'b0;
  logic [1:0]  EX_RegDst = 2'd0;
  logic [1:0]  EX_MemtoReg = 2'd0;
  logic [4:0]  EX_WrReg = 5'd0;
  logic [31:0] EX_PC = 32'd0;
  logic [31:0] MEM_ALUOut, MEM_WrData, MEM_PC;
  logic [4:0]  MEM_WrReg;
  logic [1:0]  MEM_RegDst, MEM_MemtoReg;
  logic        MEM_MemWr, MEM_MemRd, MEM_RegWr, MEM_Ovf;
  logic        Z, V, N;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .EX_ALUFun(EX_ALUFun), .EX_Sign(EX_Sign), .EX_BusA(EX_BusA), .EX_BusB(EX_BusB),
    .EX_MemWr(EX_MemWr), .EX_MemRd(EX_MemRd), .EX_RegWr(EX_RegWr),
    .EX_RegDst(EX_RegDst), .EX_MemtoReg(EX_MemtoReg), .EX_WrReg(EX_WrReg), .EX_PC(EX_PC),
    .MEM_ALUOut(MEM_ALUOut), .MEM_WrData(MEM_WrData), .MEM_PC(MEM_PC), .MEM_WrReg(MEM_WrReg),
    .MEM_RegDst(MEM_RegDst), .MEM_MemtoReg(MEM_MemtoReg), .MEM_MemWr(MEM_MemWr),
    .MEM_MemRd(MEM_MemRd), .MEM_RegWr(MEM_RegWr), .MEM_Ovf(MEM_Ovf),
    .Z(Z), .V(V), .N(N)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  function automatic logic [31:0] model_alu(input logic [5:0] f, input logic s,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] t;
    case (f[5:4])
      2'b00: return f[0] ? a - b : a + b;
      2'b01: case (f[3:0])
               4'b1000: return a & b;
               4'b1110: return a | b;
               4'b0110: return a ^ b;
               4'b0001: return ~(a | b);
               4'b1010: return a;
               default: return 32'd0;
             endcase
      2'b10: begin
        t = {{32{b[31]}}, b} >> a[4:0];
        case (f[1:0])
          2'b00:   return b << a[4:0];
          2'b01:   return b >> a[4:0];
          2'b11:   return t[31:0];
          default: return 32'd0;
        endcase
      end
      default: case (f[3:1])
               3'b001: return (a == b) ? 32'd1 : 32'd0;
               3'b000: return (a != b) ? 32'd1 : 32'd0;
               3'b010: return (s ? ($signed(a) < $signed(b)) : (a < b)) ? 32'd1 : 32'd0;
               3'b110: return ($signed(a) <= 0) ? 32'd1 : 32'd0;
               3'b101: return ($signed(a) < 0) ? 32'd1 : 32'd0;
               3'b111: return ($signed(a) > 0) ? 32'd1 : 32'd0;
               default: return 32'd0;
             endcase
    endcase
  endfunction

  function automatic logic model_v(input logic [5:0] f, input logic s,
                                   input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, r;
    if (f[5:4] != 2'b00 || !s) return 1'b0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    r   = f[0] ? sa - sbv : sa + sbv;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  function automatic exp_t make_exp();
    exp_t e;
    logic v;
    v       = model_v(EX_ALUFun, EX_Sign, EX_BusA, EX_BusB);
    e.alu   = model_alu(EX_ALUFun, EX_Sign, EX_BusA, EX_BusB);
    e.wdata = EX_BusB;
    e.pc    = EX_PC;
    e.wreg  = EX_WrReg;
    e.rdst  = EX_RegDst;
    e.m2r   = EX_MemtoReg;
    e.mw    = EX_MemWr & ~v;
    e.mr    = EX_MemRd;
    e.rw    = EX_RegWr & ~v;
    e.ovf   = v;
    return e;
  endfunction

  function automatic exp_t observe();
    return {MEM_ALUOut, MEM_WrData, MEM_PC, MEM_WrReg, MEM_RegDst, MEM_MemtoReg,
            MEM_MemWr, MEM_MemRd, MEM_RegWr, MEM_Ovf};
  endfunction

  task automatic set_ex(input logic [5:0] f, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic rw, input logic mw, input logic mr, input logic [31:0] pc);
    EX_ALUFun = f; EX_Sign = s; EX_BusA = a; EX_BusB = b;
    EX_RegWr = rw; EX_MemWr = mw; EX_MemRd = mr; EX_PC = pc;
    EX_WrReg = pc[6:2]; EX_RegDst = pc[1:0]; EX_MemtoReg = pc[3:2];
  endtask

  task automatic load(input logic [5:0] f, input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic rw, input logic mw, input logic mr, input logic [31:0] pc);
    @(negedge clk);
    set_ex(f, s, a, b, rw, mw, mr, pc);
    sb.push_back(make_exp());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t g;
    #1;
    g = observe();
    n_cmp++;
    if (g !== exp_t'(0)) begin n_err++; $display("FAIL reset_async: got %h required 0", g); end
    set_ex(6'b000000, 1'b0, 32'd9, 32'd9, 1'b1, 1'b1, 1'b1, 32'h0000_0044);
    repeat (2) @(posedge clk);
    #1;
    g = observe();
    n_cmp++;
    if (g !== exp_t'(0)) begin n_err++; $display("FAIL reset_held: got %h required 0", g); end
    @(negedge clk);
    reset = 1'b0;
    // first edge after reset release is a normal load
    set_ex(6'b000000, 1'b0, 32'd3, 32'd4, 1'b1, 1'b0, 1'b0, 32'h0000_0010);
    sb.push_back(make_exp());
    @(posedge clk);
    #1;
    g = observe();
    n_cmp++;
    if (g !== sb.pop_front() || g.alu !== 32'd7) begin
      n_err++; $display("FAIL reset_first_load: got %h alu %h required alu 7", g, g.alu);
    end
  endtask

  task automatic test_overflow();
    exp_t g, e;
    load(6'b000000, 1'b1, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b0, 32'h0000_0100);
    g = observe(); e = sb.pop_front();
    n_cmp++;
    if (g !== e || g.alu !== 32'h8000_0000 || g.ovf !== 1'b1 || g.rw !== 1'b0 || g.mw !== 1'b0) begin
      n_err++; $display("FAIL ovf_signed: got %h required %h", g, e);
    end
    load(6'b000000, 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b0, 32'h0000_0104);
    g = observe(); e = sb.pop_front();
    n_cmp++;
    if (g !== e || g.ovf !== 1'b0 || g.rw !== 1'b1 || g.mw !== 1'b1) begin
      n_err++; $display("FAIL ovf_unsigned: got %h required %h", g, e);
    end
    load(6'b000001, 1'b1, 32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0108);
    g = observe(); e = sb.pop_front();
    n_cmp++;
    if (g !== e || g.alu !== 32'h7FFF_FFFF || g.ovf !== 1'b1 || g.rw !== 1'b0) begin
      n_err++; $display("FAIL ovf_sub: got %h required %h", g, e);
    end
  endtask

  task automatic run_table(input string name, input vec_t v[]);
    exp_t g, e;
    foreach (v[i]) begin
      load(v[i].f, v[i].s, v[i].a, v[i].b, 1'b1, 1'b0, 1'b0, 32'h0000_0200 + 32'(i * 4));
      g = observe(); e = sb.pop_front();
      n_cmp++;
      if (g !== e || g.alu !== v[i].r) begin
        n_err++; $display("FAIL %s[%0d]: got alu %h required %h (full %h vs %h)", name, i, g.alu, v[i].r, g, e);
      end
    end
  endtask

  task automatic test_logic();
    vec_t v[] = '{
      '{6'b011000, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200},
      '{6'b011110, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34},
      '{6'b010110, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34},
      '{6'b010001, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h000F_00CB},
      '{6'b011010, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hF0F0_1234},
      '{6'b010111, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0000_0000}};
    run_table("logic", v);
  endtask

  task automatic test_shift();
    vec_t v[] = '{
      '{6'b100011, 1'b0, 32'd4, 32'h8000_0000, 32'hF800_0000},
      '{6'b100001, 1'b0, 32'd4, 32'h8000_0000, 32'h0800_0000},
      '{6'b100000, 1'b0, 32'd4, 32'h8000_0000, 32'h0000_0000},
      '{6'b100010, 1'b0, 32'd4, 32'h8000_0000, 32'h0000_0000},
      '{6'b100000, 1'b0, 32'h0000_0023, 32'h0000_0001, 32'h0000_0008}};
    run_table("shift", v);
  endtask

  task automatic test_compare();
    vec_t v[] = '{
      '{6'b110101, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1},
      '{6'b110101, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0},
      '{6'b111101, 1'b0, 32'd0, 32'd7, 32'd1},
      '{6'b111101, 1'b0, 32'd1, 32'd7, 32'd0},
      '{6'b110011, 1'b0, 32'd5, 32'd5, 32'd1},
      '{6'b110001, 1'b0, 32'd5, 32'd5, 32'd0},
      '{6'b111011, 1'b0, 32'h8000_0000, 32'd0, 32'd1},
      '{6'b111111, 1'b0, 32'd0, 32'd0, 32'd0}};
    run_table("compare", v);
  endtask

  task automatic test_flags();
    logic [5:0]  f[5] = '{6'b000001, 6'b000001, 6'b000000, 6'b110101, 6'b000000};
    logic        s[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] a[5] = '{32'd5, 32'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b[5] = '{32'd5, 32'd2, 32'd1, 32'd1, 32'd1};
    logic [2:0]  zvn[5] = '{3'b100, 3'b001, 3'b011, 3'b000, 3'b100};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_ex(f[i], s[i], a[i], b[i], 1'b0, 1'b0, 1'b0, 32'd0);
      #1;
      n_cmp++;
      if ({Z, V, N} !== zvn[i]) begin
        n_err++; $display("FAIL flags[%0d]: got ZVN %b required %b", i, {Z, V, N}, zvn[i]);
      end
    end
  endtask

  task automatic test_stall();
    exp_t g, held;
    load(6'b000000, 1'b0, 32'd10, 32'd20, 1'b0, 1'b1, 1'b0, 32'h0000_0300);
    g = observe(); held = sb.pop_front();
    n_cmp++;
    if (g !== held) begin n_err++; $display("FAIL stall_load: got %h required %h", g, held); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1'b1;
      set_ex(6'b011110, 1'b1, 32'h1111_0000 + 32'(i), 32'h0000_2222, 1'b1, 1'b0, 1'b1, 32'h0000_0400 + 32'(i * 4));
      @(posedge clk);
      #1;
      g = observe();
      n_cmp++;
      if (g !== held) begin n_err++; $display("FAIL stall_hold[%0d]: got %h required %h", i, g, held); end
    end
    @(negedge clk);
    stall = 1'b0;
    sb.push_back(make_exp());
    @(posedge clk);
    #1;
    g = observe(); held = sb.pop_front();
    n_cmp++;
    if (g !== held || g.alu !== 32'h1111_2222) begin
      n_err++; $display("FAIL stall_release: got %h required %h", g, held);
    end
  endtask

  task automatic test_flush();
    exp_t g, e;
    @(negedge clk);
    set_ex(6'b000000, 1'b0, 32'd3, 32'd4, 1'b1, 1'b1, 1'b1, 32'h0000_0500);
    stall = 1'b1;
    flush = 1'b1;
    e = make_exp();
    e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.ovf = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = observe(); e = sb.pop_front();
    n_cmp++;
    if (g !== e || g.alu !== 32'd7) begin n_err++; $display("FAIL flush_stall: got %h required %h", g, e); end
    @(negedge clk);
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t g, e;
    load(6'b000000, 1'b0, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0600);
    g = observe(); e = sb.pop_front();
    n_cmp++;
    if (g !== e || g.rw !== 1'b1) begin n_err++; $display("FAIL rmid_load: got %h required %h", g, e); end
    #2 reset = 1'b1;
    #1;
    g = observe();
    n_cmp++;
    if (g !== exp_t'(0)) begin n_err++; $display("FAIL rmid_async: got %h required 0", g); end
    repeat (2) @(posedge clk);
    #1;
    g = observe();
    n_cmp++;
    if (g !== exp_t'(0)) begin n_err++; $display("FAIL rmid_held: got %h required 0", g); end
    @(negedge clk);
    reset = 1'b0;
    load(6'b000000, 1'b0, 32'd8, 32'd8, 1'b1, 1'b1, 1'b1, 32'h0000_0700);
    g = observe(); e = sb.pop_front();
    // reset while stalled must drop the held instruction
    @(negedge clk);
    stall = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    g = observe();
    n_cmp++;
    if (g !== exp_t'(0)) begin n_err++; $display("FAIL rmid_stall: got %h required 0", g); end
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    load(6'b100000, 1'b0, 32'd1, 32'd3, 1'b1, 1'b0, 1'b1, 32'h0000_0800);
    g = observe(); e = sb.pop_front();
    n_cmp++;
    if (g !== e || g.alu !== 32'd6) begin n_err++; $display("FAIL rmid_release: got %h required %h", g, e); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[16] = '{6'b000000, 6'b000001, 6'b011000, 6'b011110, 6'b010110, 6'b010001,
                            6'b011010, 6'b100000, 6'b100001, 6'b100011, 6'b110011, 6'b110001,
                            6'b110101, 6'b111101, 6'b111011, 6'b111111};
    exp_t g, e;
    logic [31:0] a, b;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'd0;
      set_ex(ops[$urandom_range(0, 15)], 1'($urandom_range(0, 1)), a, b,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      sb.push_back(make_exp());
      @(posedge clk);
      #1;
      g = observe(); e = sb.pop_front();
      n_cmp++;
      if (g !== e) begin n_err++; $display("FAIL b2b[%0d]: got %h required %h", i, g, e); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_logic();
    test_shift();
    test_compare();
    test_flags();
    test_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
